// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch memory
package imem_pkg;
    localparam int IMEM_INS_W = 32;
    localparam logic [IMEM_INS_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10
    } fault_cause_t;

    typedef struct packed {
        logic                  valid;
        logic [IMEM_INS_W-1:0] instr;
        logic                  fault;
        fault_cause_t          cause;
    } fetch_stage_t;
endpackage

// File: rtl/imem_pipe_stage.sv
// imem_pipe_stage: one fetch pipeline register with stall, flush and async reset
module imem_pipe_stage
    import imem_pkg::*;
#(
    parameter logic [IMEM_INS_W-1:0] NOP_INSTR = NOP,
    parameter bit                    FIRST     = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  fetch_stage_t d,
    output fetch_stage_t q
);
    // The first stage keeps loading during flush so the redirect target survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
            q.fault <= 1'b0;
            q.cause <= FC_NONE;
        end else if (flush && !FIRST) begin
            q.valid <= 1'b0;
            q.fault <= 1'b0;
            q.cause <= FC_NONE;
        end else if (flush || !stall) begin
            q.valid <= d.valid;
            q.fault <= d.valid && d.fault;
            q.cause <= d.valid ? d.cause : FC_NONE;
            if (d.valid)
                q.instr <= d.instr;
        end
    end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: program-writable instruction memory with pipelined, fault-checked fetch
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int                    ADDR_W      = 32,
    parameter int                    INS_W       = IMEM_INS_W,
    parameter int                    DEPTH_WORDS = 64,
    parameter int                    RD_LATENCY  = 1,
    parameter logic [INS_W-1:0]      NOP_INSTR   = NOP
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fetch_req,
    input  logic [ADDR_W-1:0]              fetch_addr,
    output logic                           fetch_ready,
    input  logic                           stall,
    input  logic                           flush,
    output logic                           fetch_valid,
    output logic [INS_W-1:0]               fetch_instr,
    output logic                           fetch_fault,
    output logic [1:0]                     fault_cause,
    output logic [7:0]                     fault_count,
    input  logic                           prog_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
    input  logic [INS_W-1:0]               prog_data
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [INS_W-1:0] mem [DEPTH_WORDS] = '{default: NOP_INSTR};
    fetch_stage_t     req_stage;
    fetch_stage_t     stg [RD_LATENCY];
    logic             accept;
    logic             misalign;
    logic             range_err;
    logic [AW-1:0]    idx;

    assign fetch_ready = !stall && !prog_we;
    assign accept      = fetch_req && fetch_ready;
    assign idx         = fetch_addr[AW+1:2];
    assign misalign    = |fetch_addr[1:0];
    assign range_err   = |fetch_addr[ADDR_W-1:AW+2];

    always_ff @(posedge clk)
        if (prog_we)
            mem[prog_addr] <= prog_data;

    // Misalignment outranks range; faulted fetches never expose array data.
    always_comb begin
        req_stage.valid = accept;
        req_stage.fault = misalign || range_err;
        req_stage.cause = misalign ? FC_MISALIGN : (range_err ? FC_RANGE : FC_NONE);
        req_stage.instr = (misalign || range_err) ? NOP_INSTR : mem[idx];
    end

    for (genvar i = 0; i < RD_LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_first
            imem_pipe_stage #(.NOP_INSTR(NOP_INSTR), .FIRST(1'b1)) u_stage (
                .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
                .d(req_stage), .q(stg[i])
            );
        end else begin : g_next
            imem_pipe_stage #(.NOP_INSTR(NOP_INSTR), .FIRST(1'b0)) u_stage (
                .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
                .d(stg[i-1]), .q(stg[i])
            );
        end
    end

    assign fetch_valid = stg[RD_LATENCY-1].valid;
    assign fetch_instr = stg[RD_LATENCY-1].instr;
    assign fetch_fault = stg[RD_LATENCY-1].fault;
    assign fault_cause = stg[RD_LATENCY-1].cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_count <= 8'd0;
        else if (fetch_valid && fetch_fault && !stall && fault_count != 8'hFF)
            fault_count <= fault_count + 8'd1;
    end
endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, clocked successor to the combinational instruction ROM.
- Holds a word-organised instruction array, loadable at run time through a program-write port.
- Serves fetches from the PC through a req/ready → valid pipeline of configurable latency, with stall and flush (branch/jalr redirect).
- Reports misaligned and out-of-range fetches as faults instead of returning undefined data.

Parameters:
- ADDR_W, 32, byte-address width of fetch_addr.
- INS_W, 32, instruction width.
- DEPTH_WORDS, 64, number of instruction words; power of two, ≥4.
- RD_LATENCY, 1, cycles from accept to fetch_valid; legal values 1 or 2.
- NOP_INSTR, 32'h0000_0013, word returned on fault and driven at reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  PC presents a fetch address.
- fetch_addr  in  ADDR_W  byte address from PC.
- fetch_ready  out  1  request accepted this cycle when high with fetch_req.
- stall  in  1  downstream hold; freezes the pipeline.
- flush  in  1  kill all in-flight fetches (redirect).
- fetch_valid  out  1  fetch_instr/fetch_fault valid.
- fetch_instr  out  INS_W  fetched instruction.
- fetch_fault  out  1  response is a fault.
- fault_cause  out  2  00 none, 01 misaligned, 10 out-of-range.
- fault_count  out  8  saturating count of faulted responses.
- prog_we  in  1  program-write strobe.
- prog_addr  in  $clog2(DEPTH_WORDS)  word index to write.
- prog_data  in  INS_W  word to write.

Behaviour:
- Word index = fetch_addr[ADDR_W-1:2].
- Array initialises to NOP_INSTR at elaboration. Reset does not clear the array.
- Reset values (asynchronous, rst_n low):
  - fetch_valid=0, fetch_fault=0, fault_cause=00, fault_count=0, fetch_instr=NOP_INSTR.
  - All pipeline stage valids cleared.
- fetch_ready = !stall && !prog_we (combinational).
- Accept = fetch_req && fetch_ready.
- Latency: a request accepted at edge t yields fetch_valid at edge t+RD_LATENCY, provided no stall or flush intervenes.
- Pipeline: RD_LATENCY stages, each holding valid, instr, fault, cause.
  - Stage 1 registers the array read.
  - Stage 2 (RD_LATENCY=2) is a pure register copy.
- Stall: every stage and every output holds its value; no accept.
- Flush:
  - At the next edge all stage valids clear, including the one feeding the outputs, so fetch_valid=0 the following cycle.
  - A request accepted in the flush cycle is retained; it is the redirect target.
  - Flush has priority over stall.
- Faults:
  - Misaligned: fetch_addr[1:0]!=0, cause 01.
  - Out-of-range: word index ≥ DEPTH_WORDS, cause 10.
  - If both apply, misaligned wins.
  - A faulted response carries fetch_valid=1, fetch_fault=1, fetch_instr=NOP_INSTR. The array is not read.
- fault_count:
  - +1 on each cycle where fetch_valid && fetch_fault && !stall. A stalled, held response is counted once.
  - Saturates at 8'hFF.
- Program write:
  - Synchronous at the edge where prog_we=1.
  - A fetch cannot collide with a write because fetch_ready is low during prog_we.
  - A word written at edge t is returned by a fetch accepted at edge t+1 or later.
- fetch_valid=0 ⇒ fetch_fault and fault_cause are 0; fetch_instr holds its last value.
- Reset mid-stream drops all in-flight fetches. Array contents survive.

Decomposition:
- Package imem_pkg holds:
  - fault_cause_t enum (FC_NONE=2'b00, FC_MISALIGN=2'b01, FC_RANGE=2'b10);
  - NOP constant;
  - struct fetch_stage_t {valid, instr, fault, cause}.
- One sub-module, imem_pipe_stage: a single register stage with stall, flush and async reset, instantiated RD_LATENCY times.

Test Plan:
- Preload: prog_we writes 32'h0020_0093 to word 0 and 32'h0010_0113 to word 1. Then fetch 0x0 and 0x4 back-to-back with RD_LATENCY=1. Required: fetch_valid on the next two cycles with those words, fault=0.
- Latency check (RD_LATENCY=2): fetch 0x8 → fetch_valid exactly 2 cycles after accept. Stall held 3 cycles mid-flight → response delayed 3 cycles, value unchanged.
- Misaligned fetch 0x1E → fetch_valid=1, fetch_fault=1, cause=01, instr=32'h0000_0013, fault_count=1. Fetch 0x100 (word 64 ≥ DEPTH) → cause=10, fault_count=2.
- Flush: accept 0x10 and 0x14, assert flush together with a request to 0x40. Required: 0x10 and 0x14 never appear; the next valid returns word 16.
- Write/fetch conflict: fetch_req and prog_we (word 5, 32'hDEAD_BEEF) in the same cycle → fetch_ready=0. Fetch 0x14 next cycle → returns 32'hDEAD_BEEF.
- Reset mid-flight: rst_n low with 2 fetches in flight → outputs at reset values immediately. After release the array still holds the preloaded words.
